start_sequencer: RTL and testbench

Upstream trigger stage for the `counter` busy-timer. It collects single-cycle request pulses from the rest of the design and keeps a saturating count of pending requests. It issues exactly one `o_start` pulse per request, only when the downstream timer reports idle, and enforces a programmable dead time between runs. `o_start` drives the timer's `i_start_signal`, and the timer's `o_busy` returns as `i_busy`.

---
 rtl/start_sequencer.sv | 115 +++++++++++
 tb/tb_start_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/start_sequencer.sv
// Trigger stage ahead of the busy-timer: queues request pulses, issues one start
// per request while the timer is idle, and enforces a dead time after each run.
module start_sequencer #(
    parameter int MAX_PENDING = 7,
    parameter int GAP_CYCLES  = 2,
    parameter int PW          = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_req,
    input  logic          i_busy,
    input  logic          i_clear_ovf,
    output logic          o_start,
    output logic [PW-1:0] o_pending,
    output logic          o_full,
    output logic          o_overflow,
    output logic          o_idle
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_GAP
    } state_t;

    state_t        state_q;
    logic          start_q;
    logic [GW-1:0] gap_cnt_q;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic          inc, dec, drop;

    // A request arriving in the START cycle cancels the decrement, so it is
    // accepted even when the queue is full.
    always_comb begin
        inc        = i_req;
        dec        = (state_q == S_START);
        drop       = 1'b0;
        pending_d  = pending_q;
        if (inc && !dec) begin
            if (pending_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + PW'(1);
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - PW'(1);
        end
        overflow_d = drop ? 1'b1 : (i_clear_ovf ? 1'b0 : overflow_q);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if ((pending_q != '0) && !i_busy) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_RUN: begin
                    if (i_busy) begin
                        state_q <= S_RUN;
                    end else if (GAP_CYCLES > 0) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= GAP_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_start    = start_q;
    assign o_pending  = pending_q;
    assign o_overflow = overflow_q;
    assign o_full     = (pending_q == PEND_MAX);
    assign o_idle     = (state_q == S_IDLE) && (pending_q == '0);

endmodule

// File: tb/tb_start_sequencer.sv
// Randomised bench for start_sequencer: a bench-side timer answers each start, and a
// timestamp-based reference model predicts every output cycle by cycle.
module tb_start_sequencer;

    localparam int MAXP = 7;
    localparam int GAP  = 2;
    localparam int PW   = 3;
    localparam int NCYC = 4500;
    localparam int BIG  = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          busy = 1'b0;
    logic          clr = 1'b0;
    logic          o_start;
    logic [PW-1:0] o_pending;
    logic          o_full;
    logic          o_overflow;
    logic          o_idle;

    always #5 clk = ~clk;

    start_sequencer #(
        .MAX_PENDING (MAXP),
        .GAP_CYCLES  (GAP),
        .PW          (PW)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req       (req),
        .i_busy      (busy),
        .i_clear_ovf (clr),
        .o_start     (o_start),
        .o_pending   (o_pending),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_idle      (o_idle)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
    endtask

    // Reference model: queue length, sticky overflow, and the cycle from which
    // the sequencer may issue again (idle_at), derived from when busy falls.
    int m_pending = 0;
    bit m_ovf     = 0;
    bit m_start   = 0;
    int idle_at   = 0;
    bit waiting   = 0;
    int start_cyc = 0;

    task automatic model_step(input bit r, input bit q, input bit b, input bit c);
        bit next_start;
        bit drop;
        int np;
        if (!r) begin
            m_pending = 0;
            m_ovf     = 0;
            m_start   = 0;
            waiting   = 0;
            idle_at   = t + 1;
            return;
        end
        if (waiting && t >= start_cyc + 1 && !b) begin
            idle_at = t + 1 + GAP;
            waiting = 0;
        end
        next_start = (t >= idle_at) && (m_pending > 0) && !b;
        np   = m_pending;
        drop = 0;
        if (q && !m_start) begin
            if (m_pending < MAXP) np = m_pending + 1;
            else drop = 1;
        end else if (m_start && !q) begin
            np = m_pending - 1;
        end
        m_ovf     = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_pending = np;
        m_start   = next_start;
        if (next_start) begin
            waiting   = 1;
            start_cyc = t + 1;
            idle_at   = BIG;
        end
    endtask

    int tmr_cnt  = 0;
    int fgn_cnt  = 0;
    int rst_hold = 0;
    int n_starts = 0;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_start",   int'(o_start),    0);
        check("reset_pending", int'(o_pending),  0);
        check("reset_full",    int'(o_full),     0);
        check("reset_ovf",     int'(o_overflow), 0);
        check("reset_idle",    int'(o_idle),     1);
        rst_n = 1'b1;
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        t = 0;
        idle_at = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int req_div;
            int clr_div;
            int blo;
            int bhi;
            @(negedge clk);
            t = cyc;
            check("start",   int'(o_start),    int'(m_start));
            check("pending", int'(o_pending),  m_pending);
            check("full",    int'(o_full),     int'(m_pending == MAXP));
            check("ovf",     int'(o_overflow), int'(m_ovf));
            check("idle",    int'(o_idle),     int'((t >= idle_at) && (m_pending == 0)));

            if (cyc < 1500) begin
                req_div = 8;  clr_div = 30; blo = 0;  bhi = 25;
            end else if (cyc < 3000) begin
                req_div = 2;  clr_div = 12; blo = 15; bhi = 30;
            end else begin
                req_div = 4;  clr_div = 10; blo = 0;  bhi = 20;
            end

            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else if (cyc >= 3000 && waiting && $urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                rst_hold = $urandom_range(0, 2);
                #1;
                check("async_start",   int'(o_start),    0);
                check("async_pending", int'(o_pending),  0);
                check("async_ovf",     int'(o_overflow), 0);
                check("async_idle",    int'(o_idle),     1);
            end else begin
                rst_n = 1'b1;
            end

            req  = ($urandom_range(0, req_div - 1) == 0);
            clr  = ($urandom_range(0, clr_div - 1) == 0);
            busy = (tmr_cnt > 0) || (fgn_cnt > 0);

            if (fgn_cnt > 0) fgn_cnt--;
            else if ($urandom_range(0, 119) == 0) fgn_cnt = $urandom_range(1, 12);

            if (o_start) begin
                n_starts++;
                $display("cycle %0d: start #%0d pending=%0d ovf=%0d", cyc, n_starts, o_pending, o_overflow);
                tmr_cnt = $urandom_range(blo, bhi);
            end else if (tmr_cnt > 0) begin
                tmr_cnt--;
            end

            model_step(rst_n, req, busy, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
